fir_seq_ctrl: RTL and testbench

Sequencer for the 31-tap 12-bit symmetric FIR filter cores (low-pass and high-pass variants). It divides `clk` down to the sample strobe `f_s` and buffers one input sample behind a valid/ready handshake. On each start it flushes the filter history with zeros, then feeds one sample per strobe and returns one filtered sample per strobe. It sits between the sample source (ADC front end or test pattern generator) and the FIR core, and it owns the core's `f_s`, `en` and `din` inputs.

---
 rtl/fir_seq_ctrl_if.sv | 30 +++
 rtl/fir_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// Sequencer-side bus: control, sample-in handshake, FIR core drive/return and filtered-sample out.
// master is the sequencer view; slave is the source/core/sink environment view.
interface fir_seq_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] div;
  logic             in_valid;
  logic [11:0]      in_data;
  logic             in_ready;
  logic             fir_f_s;
  logic             fir_en;
  logic [11:0]      fir_din;
  logic [11:0]      fir_dout;
  logic             out_valid;
  logic [11:0]      out_data;
  logic             busy;
  logic [7:0]       underrun_cnt;

  modport master (
    input  start, stop, div, in_valid, in_data, fir_dout,
    output in_ready, fir_f_s, fir_en, fir_din, out_valid, out_data, busy, underrun_cnt
  );

  modport slave (
    output start, stop, div, in_valid, in_data, fir_dout,
    input  in_ready, fir_f_s, fir_en, fir_din, out_valid, out_data, busy, underrun_cnt
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: divides clk to f_s, flushes core history with zeros on start, then feeds one sample per strobe.
// out_valid fires 4 cycles after each RUN period start; in_ready drops while the one-entry buffer is full.
module fir_seq_ctrl #(
  parameter int TAPS     = 31,
  parameter int PIPE_LAT = 4,
  parameter int DIV_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  fir_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_RUN} state_t;

  localparam int                FLUSH_N    = TAPS + PIPE_LAT;
  localparam int                FC_W       = $clog2(FLUSH_N + 1);
  localparam logic [FC_W-1:0]   FLUSH_LAST = FC_W'(FLUSH_N);
  localparam logic [DIV_W-1:0]  DIV_MIN    = DIV_W'(3);
  localparam logic [DIV_W-1:0]  CAP_CNT    = DIV_W'(3);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             stop_q, stop_d;
  logic [11:0]      buf_q, buf_d;
  logic             full_q, full_d;
  logic [11:0]      din_q, din_d;
  logic             en_q, en_d;
  logic [11:0]      odat_q, odat_d;
  logic             ovld_q, ovld_d;
  logic [7:0]       urun_q, urun_d;

  logic busy;
  logic in_rdy;
  logic accept;
  logic period_start;
  logic period_end;
  logic stop_seen;

  assign busy         = (state_q != ST_IDLE);
  assign in_rdy       = busy & ~full_q;
  assign accept       = bus.in_valid & in_rdy;
  assign period_start = busy && (cnt_q == '0);
  assign period_end   = busy && (cnt_q == div_q);
  assign stop_seen    = stop_q | bus.stop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    fcnt_d  = fcnt_q;
    stop_d  = stop_q;
    buf_d   = buf_q;
    full_d  = full_q;
    din_d   = din_q;
    en_d    = en_q;
    odat_d  = odat_q;
    ovld_d  = 1'b0;
    urun_d  = urun_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FLUSH;
          div_d   = (bus.div < DIV_MIN) ? DIV_MIN : bus.div;
          cnt_d   = '0;
          fcnt_d  = '0;
          stop_d  = 1'b0;
          full_d  = 1'b0;
          urun_d  = '0;
        end
      end

      default: begin
        if (bus.stop) stop_d = 1'b1;
        cnt_d = period_end ? '0 : cnt_q + DIV_W'(1);

        // Consume first: with in_ready = ~full a consume and an accept never coincide.
        if (period_start) begin
          if (state_q == ST_FLUSH) begin
            din_d  = '0;
            en_d   = 1'b1;
            fcnt_d = fcnt_q + FC_W'(1);
          end else if (full_q) begin
            din_d  = buf_q;
            en_d   = 1'b1;
            full_d = 1'b0;
          end else begin
            en_d = 1'b0;
            if (urun_q != 8'hFF) urun_d = urun_q + 8'd1;
          end
        end

        if (accept) begin
          buf_d  = bus.in_data;
          full_d = 1'b1;
        end

        // With div_q == 3 the capture cycle is also the last one; a stop then suppresses it.
        if (state_q == ST_RUN && cnt_q == CAP_CNT && !(period_end && stop_seen)) begin
          odat_d = bus.fir_dout;
          ovld_d = 1'b1;
        end

        if (period_end) begin
          if (stop_seen) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
            en_d    = 1'b0;
            cnt_d   = '0;
          end else if (state_q == ST_FLUSH && fcnt_q == FLUSH_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_MIN;
      fcnt_q  <= '0;
      stop_q  <= 1'b0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      din_q   <= '0;
      en_q    <= 1'b0;
      odat_q  <= '0;
      ovld_q  <= 1'b0;
      urun_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      fcnt_q  <= fcnt_d;
      stop_q  <= stop_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      din_q   <= din_d;
      en_q    <= en_d;
      odat_q  <= odat_d;
      ovld_q  <= ovld_d;
      urun_q  <= urun_d;
    end
  end

  assign bus.fir_f_s      = busy && (cnt_q <= DIV_W'(1));
  assign bus.fir_en       = en_q;
  assign bus.fir_din      = din_q;
  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = ovld_q;
  assign bus.out_data     = odat_q;
  assign bus.busy         = busy;
  assign bus.underrun_cnt = urun_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: table of divider settings plus directed underrun, backpressure, stop and reset sequences.
// A 4-strobe identity delay line stands in for the FIR core so latency is observable.
module tb_fir_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_seq_ctrl_if #(.DIV_W(16)) bus();

  fir_seq_ctrl #(.TAPS(31), .PIPE_LAT(4), .DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Core stand-in: on each strobe (second f_s high cycle) with en, dout takes the sample from 4 strobes ago.
  logic [11:0] pipe [4] = '{default: 12'd0};
  logic [11:0] core_dout = 12'd0;
  logic        m_prev = 1'b0;
  assign bus.fir_dout = core_dout;

  always @(negedge clk) begin
    if (bus.fir_f_s && m_prev && bus.fir_en) begin
      core_dout = pipe[3];
      pipe[3]   = pipe[2];
      pipe[2]   = pipe[1];
      pipe[1]   = pipe[0];
      pipe[0]   = bus.fir_din;
    end
    m_prev = bus.fir_f_s;
  end

  typedef struct {
    logic [15:0] div;
    int          per;
    int          first;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.in_valid = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},    32'(bus.busy),         32'd0);
    chk({tag, "_fs"},      32'(bus.fir_f_s),      32'd0);
    chk({tag, "_en"},      32'(bus.fir_en),       32'd0);
    chk({tag, "_din"},     32'(bus.fir_din),      32'd0);
    chk({tag, "_ovld"},    32'(bus.out_valid),    32'd0);
    chk({tag, "_odat"},    32'(bus.out_data),     32'd0);
    chk({tag, "_in_rdy"},  32'(bus.in_ready),     32'd0);
    chk({tag, "_underrun"}, 32'(bus.underrun_cnt), 32'd0);
  endtask

  // Waits for the next strobe (cnt == 1 cycle), counting out_valid pulses seen on the way.
  task automatic wait_strobe(output int pulses);
    logic p;
    int   b;
    pulses = 0;
    b      = 0;
    p      = bus.fir_f_s;
    forever begin
      @(negedge clk);
      b++;
      if (bus.out_valid) pulses++;
      if (bus.fir_f_s && p) break;
      p = bus.fir_f_s;
      if (b > 200) begin
        checks++;
        errors++;
        $display("FAIL strobe_timeout waited=%0d required<=200", b);
        break;
      end
    end
  endtask

  task automatic measure(input logic [15:0] d, input int exp_per, input int exp_first);
    int          t0, first, second, nstr, nzero, fs_hi, np, b;
    logic        prev;
    logic [11:0] d1, d4, d5;
    first = 0; second = 0; nstr = 0; nzero = 0; fs_hi = 0; np = 0; b = 0;
    prev = 1'b0; d1 = '0; d4 = '0; d5 = '0;
    bus.in_valid = 1'b1;
    bus.in_data  = 12'd100;
    bus.div      = d;
    bus.start    = 1'b1;
    t0           = cyc;
    step(1);
    bus.start = 1'b0;
    while (np < 5 && b < 4000) begin
      @(negedge clk);
      b++;
      if (np == 0 && bus.fir_f_s && prev) begin
        nstr++;
        if (bus.fir_din == 12'd0 && bus.fir_en == 1'b1) nzero++;
      end
      if (np == 1 && bus.fir_f_s) fs_hi++;
      if (bus.out_valid) begin
        np++;
        case (np)
          1: begin first = cyc - t0; d1 = bus.out_data; end
          2: second = cyc - t0;
          4: d4 = bus.out_data;
          5: d5 = bus.out_data;
          default: ;
        endcase
      end
      prev = bus.fir_f_s;
    end
    if (np < 5) begin
      checks++;
      errors++;
      $display("FAIL measure_timeout div=%0d pulses=%0d required=5", d, np);
    end
    chk($sformatf("first_valid_div%0d", d),   first,          exp_first);
    chk($sformatf("period_div%0d", d),        second - first, exp_per);
    chk($sformatf("strobes_pre_out_div%0d", d), nstr,         36);
    chk($sformatf("flush_zero_div%0d", d),    nzero,          35);
    chk($sformatf("fs_high_div%0d", d),       fs_hi,          2);
    chk($sformatf("out1_div%0d", d),          32'(d1),        32'd0);
    chk($sformatf("out4_div%0d", d),          32'(d4),        32'd0);
    chk($sformatf("out5_div%0d", d),          32'(d5),        32'd100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, tot, bad;

    tbl[0] = '{div: 16'd0,  per: 4,  first: 145};
    tbl[1] = '{div: 16'd1,  per: 4,  first: 145};
    tbl[2] = '{div: 16'd2,  per: 4,  first: 145};
    tbl[3] = '{div: 16'd3,  per: 4,  first: 145};
    tbl[4] = '{div: 16'd20, per: 21, first: 740};
    tbl[5] = '{div: 16'd9,  per: 10, first: 355};

    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.div      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    for (int i = 0; i < 6; i++) begin
      do_reset();
      measure(tbl[i].div, tbl[i].per, tbl[i].first);
    end

    // Underrun: the buffered word drains, then three empty periods.
    bus.in_valid = 1'b0;
    wait_strobe(p);
    chk("drain_en", 32'(bus.fir_en), 32'd1);
    chk("drain_din", 32'(bus.fir_din), 32'd100);
    tot = 0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(p);
      tot += p;
      chk($sformatf("underrun_en%0d", k), 32'(bus.fir_en), 32'd0);
    end
    chk("underrun_din_hold", 32'(bus.fir_din), 32'd100);
    chk("underrun_pulses", tot, 3);
    chk("underrun_cnt3", 32'(bus.underrun_cnt), 32'd3);
    bus.in_valid = 1'b1;
    wait_strobe(p);
    chk("resume_en", 32'(bus.fir_en), 32'd1);
    bus.in_valid = 1'b0;
    repeat (300) wait_strobe(p);
    chk("underrun_sat", 32'(bus.underrun_cnt), 32'd255);

    // Backpressure: buffer filled mid-period, second word offered in the cnt == 0 cycle.
    step(4);
    bus.in_valid = 1'b1;
    bus.in_data  = 12'h4D2;
    @(negedge clk);
    chk("bp_rdy_empty", 32'(bus.in_ready), 32'd1);
    step(1);
    bus.in_valid = 1'b0;
    step(4);
    bus.in_valid = 1'b1;
    bus.in_data  = 12'hFFB;
    @(negedge clk);
    chk("bp_rdy_cnt0", 32'(bus.in_ready), 32'd0);
    chk("bp_fs_cnt0", 32'(bus.fir_f_s), 32'd1);
    step(1);
    @(negedge clk);
    chk("bp_rdy_cnt1", 32'(bus.in_ready), 32'd1);
    chk("bp_din_a", 32'(bus.fir_din), 32'h4D2);
    chk("bp_en_a", 32'(bus.fir_en), 32'd1);
    step(1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_rdy_full", 32'(bus.in_ready), 32'd0);
    wait_strobe(p);
    chk("bp_din_b", 32'(bus.fir_din), 32'hFFB);
    chk("bp_en_b", 32'(bus.fir_en), 32'd1);

    // Stop at cnt == 2 with a simultaneous start that must be ignored.
    step(1);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    bus.div   = 16'd0;
    @(negedge clk);
    chk("stop_busy_cnt2", 32'(bus.busy), 32'd1);
    step(1);
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    step(1);
    @(negedge clk);
    chk("stop_ovld_cnt4", 32'(bus.out_valid), 32'd1);
    step(5);
    @(negedge clk);
    chk("stop_busy_cnt9", 32'(bus.busy), 32'd1);
    step(1);
    @(negedge clk);
    chk("stop_idle", 32'(bus.busy), 32'd0);
    chk("stop_fs", 32'(bus.fir_f_s), 32'd0);
    chk("stop_rdy", 32'(bus.in_ready), 32'd0);
    chk("stop_ovld", 32'(bus.out_valid), 32'd0);
    chk("stop_en", 32'(bus.fir_en), 32'd0);
    chk("stop_start_ignored", 32'(bus.underrun_cnt), 32'd255);
    bus.in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.busy || bus.fir_f_s || bus.out_valid || bus.in_ready) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Reset in the middle of FLUSH, then a full restart.
    bus.in_data = 12'd100;
    bus.div     = 16'd9;
    bus.start   = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(50);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check_zero("midflush_rst");
    measure(16'd9, 10, 355);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
